// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the accumulator CPU control path.
//   - opcode encodings (IR[7:5])
//   - cpu_state_t: the eight fetch/execute phases plus HALTED
//   - cpu_strobe_t: the datapath strobe bundle driven by the decoder
//   - is_aluop(): opcodes that read a memory operand and load the accumulator
package cpu_pkg;

    localparam logic [2:0] HLT = 3'b000;
    localparam logic [2:0] SKZ = 3'b001;
    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] AND = 3'b011;
    localparam logic [2:0] XOR = 3'b100;
    localparam logic [2:0] LDA = 3'b101;
    localparam logic [2:0] STO = 3'b110;
    localparam logic [2:0] JMP = 3'b111;

    // Low 3 bits walk the eight phases in order; bit 3 marks HALTED.
    typedef enum logic [3:0] {
        S_INST_ADDR  = 4'd0,
        S_INST_FETCH = 4'd1,
        S_INST_LOAD  = 4'd2,
        S_IDLE       = 4'd3,
        S_OP_ADDR    = 4'd4,
        S_OP_FETCH   = 4'd5,
        S_ALU_OP     = 4'd6,
        S_STORE      = 4'd7,
        S_HALTED     = 4'd8
    } cpu_state_t;

    typedef struct packed {
        logic sel;
        logic rd;
        logic wr;
        logic ld_ir;
        logic ld_ac;
        logic ld_pc;
        logic inc_pc;
        logic data_e;
        logic halt;
    } cpu_strobe_t;

    function automatic logic is_aluop(input logic [2:0] op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/cpu_ctl_decode.sv
// cpu_ctl_decode: purely combinational strobe decode for the sequencer.
// Ports:
//   i_state  in  current phase
//   i_opcode in  IR[7:5]
//   i_zero   in  registered accumulator-zero flag
//   o_stb    out datapath strobes (sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt)
module cpu_ctl_decode
    import cpu_pkg::*;
(
    input  cpu_state_t  i_state,
    input  logic [2:0]  i_opcode,
    input  logic        i_zero,
    output cpu_strobe_t o_stb
);

    logic w_aluop;
    assign w_aluop = is_aluop(i_opcode);

    always_comb begin
        o_stb = '0;
        case (i_state)
            S_INST_ADDR: begin
                o_stb.sel = 1'b1;
            end
            S_INST_FETCH: begin
                o_stb.sel = 1'b1;
                o_stb.rd  = 1'b1;
            end
            // ld_ir spans INST_LOAD and IDLE so the IR sees a stable bus
            // for two edges.
            S_INST_LOAD, S_IDLE: begin
                o_stb.sel   = 1'b1;
                o_stb.rd    = 1'b1;
                o_stb.ld_ir = 1'b1;
            end
            S_OP_ADDR: begin
                o_stb.inc_pc = 1'b1;
                o_stb.halt   = (i_opcode == HLT);
            end
            S_OP_FETCH: begin
                o_stb.rd = w_aluop;
            end
            S_ALU_OP: begin
                o_stb.rd     = w_aluop;
                o_stb.inc_pc = (i_opcode == SKZ) && i_zero;
                o_stb.ld_pc  = (i_opcode == JMP);
                // data_e leads wr by a cycle so the bus is settled at the write.
                o_stb.data_e = (i_opcode == STO);
            end
            S_STORE: begin
                o_stb.rd     = w_aluop;
                o_stb.ld_ac  = w_aluop;
                o_stb.ld_pc  = (i_opcode == JMP);
                o_stb.wr     = (i_opcode == STO);
                o_stb.data_e = (i_opcode == STO);
            end
            S_HALTED: begin
                o_stb.halt = 1'b1;
            end
            default: begin
                o_stb = '0;
            end
        endcase
    end

endmodule

// File: rtl/cpu_ctl_seq.sv
// cpu_ctl_seq: instruction sequencer for the 8-bit accumulator CPU.
// Steps each instruction through eight fetch/execute phases, waits on
// mem_ready in both fetch phases, parks in HALTED on HLT until resume,
// and counts retired instructions.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   opcode, zero        IR[7:5] and accumulator-zero flag
//   mem_ready           memory handshake for INST_FETCH / OP_FETCH
//   resume              leave HALTED
//   sel..data_e, halt   combinational datapath strobes
//   instr_cnt           retired-instruction count (registered, wraps)
module cpu_ctl_seq
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    input  logic             resume,
    output logic             sel,
    output logic             rd,
    output logic             wr,
    output logic             ld_ir,
    output logic             ld_ac,
    output logic             ld_pc,
    output logic             inc_pc,
    output logic             data_e,
    output logic             halt,
    output logic [CNT_W-1:0] instr_cnt
);

    cpu_state_t       r_state;
    cpu_state_t       w_next;
    logic [CNT_W-1:0] r_cnt;
    cpu_strobe_t      w_stb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_INST_ADDR;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INST_ADDR:  w_next = S_INST_FETCH;
            S_INST_FETCH: w_next = mem_ready ? S_INST_LOAD : S_INST_FETCH;
            S_INST_LOAD:  w_next = S_IDLE;
            S_IDLE:       w_next = S_OP_ADDR;
            S_OP_ADDR:    w_next = (opcode == HLT) ? S_HALTED : S_OP_FETCH;
            // Only operand-reading opcodes touch memory here.
            S_OP_FETCH:   w_next = (is_aluop(opcode) && !mem_ready) ? S_OP_FETCH : S_ALU_OP;
            S_ALU_OP:     w_next = S_STORE;
            S_STORE:      w_next = S_INST_ADDR;
            S_HALTED:     w_next = resume ? S_INST_ADDR : S_HALTED;
            default:      w_next = S_INST_ADDR;
        endcase
    end

    // STORE always lasts one cycle, so its exit edge is any edge seen in STORE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_cnt <= '0;
        else if (r_state == S_STORE) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    cpu_ctl_decode u_decode (
        .i_state  (r_state),
        .i_opcode (opcode),
        .i_zero   (zero),
        .o_stb    (w_stb)
    );

    assign sel       = w_stb.sel;
    assign rd        = w_stb.rd;
    assign wr        = w_stb.wr;
    assign ld_ir     = w_stb.ld_ir;
    assign ld_ac     = w_stb.ld_ac;
    assign ld_pc     = w_stb.ld_pc;
    assign inc_pc    = w_stb.inc_pc;
    assign data_e    = w_stb.data_e;
    assign halt      = w_stb.halt;
    assign instr_cnt = r_cnt;

endmodule

// File: tb/tb_cpu_ctl_seq.sv
// Bench for cpu_ctl_seq. Strobes are compared as a 9-bit vector
// {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt}.
// A 3-bit counter width is used so the wrap is reached quickly.
module tb_cpu_ctl_seq;

    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             resume;
    logic             sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;
    logic [CNT_W-1:0] instr_cnt;

    cpu_ctl_seq #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .resume    (resume),
        .sel       (sel),
        .rd        (rd),
        .wr        (wr),
        .ld_ir     (ld_ir),
        .ld_ac     (ld_ac),
        .ld_pc     (ld_pc),
        .inc_pc    (inc_pc),
        .data_e    (data_e),
        .halt      (halt),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    wire [8:0] stb = {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Execute-phase expectations, packed {STORE, ALU_OP, OP_FETCH, OP_ADDR}.
    typedef struct {
        logic [2:0]      op;
        logic            z;
        logic [3:0][8:0] ex;
    } vec_t;

    vec_t             vecs [8];
    logic [3:0][8:0]  fetch;
    logic [CNT_W-1:0] exp_cnt;
    logic [8:0]       e;
    logic [8:0]       wexp [13];
    logic             wmr  [13];

    initial begin
        fetch   = {9'h1A0, 9'h1A0, 9'h180, 9'h100};
        vecs[0] = '{3'b010, 1'b1, {9'h090, 9'h080, 9'h080, 9'h004}}; // ADD
        vecs[1] = '{3'b011, 1'b0, {9'h090, 9'h080, 9'h080, 9'h004}}; // AND
        vecs[2] = '{3'b100, 1'b1, {9'h090, 9'h080, 9'h080, 9'h004}}; // XOR
        vecs[3] = '{3'b101, 1'b0, {9'h090, 9'h080, 9'h080, 9'h004}}; // LDA
        vecs[4] = '{3'b110, 1'b1, {9'h042, 9'h002, 9'h000, 9'h004}}; // STO
        vecs[5] = '{3'b001, 1'b1, {9'h000, 9'h004, 9'h000, 9'h004}}; // SKZ taken
        vecs[6] = '{3'b001, 1'b0, {9'h000, 9'h000, 9'h000, 9'h004}}; // SKZ not taken
        vecs[7] = '{3'b111, 1'b1, {9'h008, 9'h008, 9'h000, 9'h004}}; // JMP

        rst_n = 1'b0; mem_ready = 1'b1; resume = 1'b0; opcode = 3'b010; zero = 1'b0;
        exp_cnt = '0;
        #12;
        chk("reset_stb", 16'(stb), 16'h100);
        chk("reset_cnt", 16'(instr_cnt), 16'(exp_cnt));
        rst_n = 1'b1;
        #1;

        // Table: one full 8-cycle instruction per entry.
        for (int i = 0; i < 8; i++) begin
            opcode = vecs[i].op;
            zero   = vecs[i].z;
            for (int c = 0; c < 8; c++) begin
                e = (c < 4) ? fetch[c] : vecs[i].ex[c-4];
                chk($sformatf("vec%0d_cyc%0d", i, c + 1), 16'(stb), 16'(e));
                step();
            end
            exp_cnt = exp_cnt + 1'b1;
            chk($sformatf("vec%0d_cnt", i), 16'(instr_cnt), 16'(exp_cnt));
        end

        // STO with mem_ready low in execute and resume high: both ignored.
        opcode = 3'b110; zero = 1'b0; resume = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c >= 4) mem_ready = 1'b0;
            e = (c < 4) ? fetch[c] : vecs[4].ex[c-4];
            chk($sformatf("sto_ign_cyc%0d", c + 1), 16'(stb), 16'(e));
            step();
        end
        mem_ready = 1'b1; resume = 1'b0;
        exp_cnt = exp_cnt + 1'b1;
        chk("sto_ign_cnt", 16'(instr_cnt), 16'(exp_cnt));

        // LDA with 3 + 2 wait cycles: 13 cycles total.
        wexp = '{9'h100, 9'h180, 9'h180, 9'h180, 9'h180, 9'h1A0, 9'h1A0,
                 9'h004, 9'h080, 9'h080, 9'h080, 9'h080, 9'h090};
        wmr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        opcode = 3'b101;
        for (int c = 0; c < 13; c++) begin
            mem_ready = wmr[c];
            chk($sformatf("wait_cyc%0d", c + 1), 16'(stb), 16'(wexp[c]));
            step();
        end
        mem_ready = 1'b1;
        exp_cnt = exp_cnt + 1'b1;
        chk("wait_end_stb", 16'(stb), 16'h100);
        chk("wait_cnt", 16'(instr_cnt), 16'(exp_cnt));

        // HLT: halt in OP_ADDR, then HALTED until resume.
        opcode = 3'b000; zero = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("hlt_cyc%0d", c + 1), 16'(stb), 16'(fetch[c]));
            step();
        end
        chk("hlt_opaddr", 16'(stb), 16'h005);
        step();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("halted%0d", c), 16'(stb), 16'h001);
            step();
        end
        resume = 1'b1;
        chk("halted_resume", 16'(stb), 16'h001);
        step();
        resume = 1'b0;
        chk("resumed_stb", 16'(stb), 16'h100);
        chk("hlt_cnt", 16'(instr_cnt), 16'(exp_cnt));

        // Async reset in the middle of an INST_FETCH wait.
        opcode = 3'b101;
        step();
        mem_ready = 1'b0;
        step();
        chk("stall_stb", 16'(stb), 16'h180);
        rst_n = 1'b0;
        #1;
        chk("async_rst_stb", 16'(stb), 16'h100);
        chk("async_rst_cnt", 16'(instr_cnt), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
